// File: rtl/pc_sequencer_if.sv
// Fetch/execute bus between the PC sequencer, instruction memory and the datapath.
// master = sequencer side, slave = imem/datapath side.
interface pc_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ready;
  logic             instr_valid;
  logic             stall_i;
  logic             pc_src;
  logic [WIDTH-1:0] pc_target;
  logic             halt_i;
  logic [WIDTH-1:0] pc_o;
  logic [WIDTH-1:0] pc_plus4_o;
  logic             trap_o;
  logic [WIDTH-1:0] epc_o;
  logic             halted_o;
  logic [WIDTH-1:0] retire_cnt;

  modport master (
    output imem_req, imem_addr, instr_valid, pc_o, pc_plus4_o,
           trap_o, epc_o, halted_o, retire_cnt,
    input  imem_ready, stall_i, pc_src, pc_target, halt_i
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, pc_o, pc_plus4_o,
           trap_o, epc_o, halted_o, retire_cnt,
    output imem_ready, stall_i, pc_src, pc_target, halt_i
  );
endinterface

// File: rtl/pc_sequencer.sv
// Architectural PC owner for the RV32I core: sequences FETCH/EXEC, takes
// misaligned-target traps and halts on ecall/ebreak until reset.
module pc_sequencer #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic           clk,
  input  logic           rst_n,
  pc_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_TRAP  = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] epc_q;
  logic [WIDTH-1:0] cnt_q;
  logic             req_q;
  logic             vld_q;
  logic             trap_q;
  logic             halted_q;

  logic [WIDTH-1:0] pc_plus4_d;
  logic [WIDTH-1:0] pc_next_d;
  logic [WIDTH-1:0] cnt_d;
  logic             misalign_d;

  assign pc_plus4_d = pc_q + WIDTH'(4);
  assign pc_next_d  = bus.pc_src ? bus.pc_target : pc_plus4_d;
  assign cnt_d      = cnt_q + WIDTH'(1);
  // Target alignment only matters when the target is actually being taken.
  assign misalign_d = bus.pc_src && (bus.pc_target[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_RESET;
      pc_q     <= RESET_VECTOR;
      epc_q    <= '0;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      vld_q    <= 1'b0;
      trap_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      trap_q <= 1'b0;
      case (state_q)
        S_RESET: begin
          state_q <= S_FETCH;
          req_q   <= 1'b1;
        end
        S_FETCH: begin
          if (bus.imem_ready) begin
            state_q <= S_EXEC;
            req_q   <= 1'b0;
            vld_q   <= 1'b1;
          end
        end
        S_EXEC: begin
          if (!bus.stall_i) begin
            vld_q <= 1'b0;
            // halt wins over any redirect or misalignment in the same cycle
            if (bus.halt_i) begin
              cnt_q    <= cnt_d;
              state_q  <= S_HALT;
              halted_q <= 1'b1;
            end else if (misalign_d) begin
              epc_q   <= pc_q;
              pc_q    <= TRAP_VECTOR;
              state_q <= S_TRAP;
              trap_q  <= 1'b1;
            end else begin
              pc_q    <= pc_next_d;
              cnt_q   <= cnt_d;
              state_q <= S_FETCH;
              req_q   <= 1'b1;
            end
          end
        end
        S_TRAP: begin
          state_q <= S_FETCH;
          req_q   <= 1'b1;
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_RESET;
          req_q   <= 1'b0;
          vld_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = vld_q;
  assign bus.pc_o        = pc_q;
  assign bus.pc_plus4_o  = pc_plus4_d;
  assign bus.trap_o      = trap_q;
  assign bus.epc_o       = epc_q;
  assign bus.halted_o    = halted_q;
  assign bus.retire_cnt  = cnt_q;

endmodule
